// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared state encoding and frame layout for the ADC sample scheduler
package adc_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_START,
      ST_CONVERT,
      ST_SEND_HI,
      ST_SEND_LO
   } state_t;

   // Bit 7 of the first byte marks the start of a frame for the receiver.
   localparam logic [7:0] FRAME_MARKER  = 8'h80;
   localparam int         FRAME_HI_LSB  = 8;
   localparam int         FRAME_HI_BITS = 4;
   localparam int         FRAME_LO_BITS = 8;

   // First byte of a frame: marker, three zero bits, then the upper nibble of the average.
   function automatic logic [7:0] frame_hi_byte(input logic [FRAME_HI_BITS-1:0] nib);
      return FRAME_MARKER | {{(8 - FRAME_HI_BITS){1'b0}}, nib};
   endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// rtl/adc_tick_gen.sv - periodic one-cycle sample tick, cleared while not running
module adc_tick_gen #(
   parameter int PERIOD_CYCLES = 50000
) (
   input  logic clk_adc,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int                CNT_W  = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // Down-counter sits at 0 when stopped; the first running cycle loads it so the
   // first tick lands PERIOD_CYCLES cycles after run rises, then every PERIOD_CYCLES.
   always_ff @(posedge clk_adc or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!run) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_cnt == CNT_W'(1));
         r_cnt  <= (r_cnt == '0) ? RELOAD : r_cnt - CNT_W'(1);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - ticks ADC conversions, averages results, sends two-byte frames
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int DATA_BITS      = 12,
   parameter int PERIOD_CYCLES  = 50000,
   parameter int AVG_LOG2       = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk_adc,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic                 adc_start,
   input  logic                 adc_done,
   input  logic [DATA_BITS-1:0] adc_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [7:0]           tx_data,
   output logic                 overrun,
   output logic                 timeout_err,
   input  logic                 clr_err,
   output logic [15:0]          frame_count
);

   localparam int                ACC_W    = DATA_BITS + AVG_LOG2;
   localparam int                IDX_W    = AVG_LOG2 + 1;
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(1 << AVG_LOG2);
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_next;
   state_t                 w_rest;
   logic [ACC_W-1:0]       r_acc;
   logic [IDX_W-1:0]       r_idx;
   logic [TMO_W-1:0]       r_tmo;
   logic [DATA_BITS-1:0]   r_frame;
   logic                   r_adc_start;
   logic                   r_tx_valid;
   logic [7:0]             r_tx_data;
   logic                   r_overrun;
   logic                   r_timeout_err;
   logic [15:0]            r_frame_count;

   logic                   w_run;
   logic                   w_tick;
   logic [ACC_W-1:0]       w_sum;
   logic [IDX_W-1:0]       w_idx_inc;
   logic                   w_last;
   logic [DATA_BITS-1:0]   w_avg;
   logic [FRAME_HI_BITS-1:0] w_hi_nib;
   logic                   w_tmo_hit;
   logic                   w_tick_drop;

   assign w_run = (r_state != ST_IDLE);

   adc_tick_gen #(
      .PERIOD_CYCLES (PERIOD_CYCLES)
   ) u_tick_gen (
      .clk_adc (clk_adc),
      .rst_n   (rst_n),
      .run     (w_run),
      .tick    (w_tick)
   );

   assign w_sum       = r_acc + ACC_W'(adc_data);
   assign w_idx_inc   = r_idx + IDX_W'(1);
   assign w_last      = (w_idx_inc == IDX_FULL);
   assign w_avg       = w_sum[ACC_W-1 -: DATA_BITS];
   assign w_hi_nib    = FRAME_HI_BITS'(w_avg >> FRAME_HI_LSB);
   assign w_tmo_hit   = (r_state == ST_CONVERT) && !adc_done && (r_tmo == TMO_LAST);
   assign w_tick_drop = w_tick && (r_state != ST_WAIT_TICK) && (r_state != ST_IDLE);
   // Wherever the flow would come back to WAIT_TICK, a low enable diverts it to IDLE.
   assign w_rest      = enable ? ST_WAIT_TICK : ST_IDLE;

   // State register.
   always_ff @(posedge clk_adc or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (enable) w_next = ST_WAIT_TICK;
         ST_WAIT_TICK: begin
            if (!enable)     w_next = ST_IDLE;
            else if (w_tick) w_next = ST_START;
         end
         ST_START:     w_next = ST_CONVERT;
         ST_CONVERT: begin
            if (adc_done)       w_next = w_last ? ST_SEND_HI : w_rest;
            else if (w_tmo_hit) w_next = w_rest;
         end
         ST_SEND_HI:   if (tx_ready) w_next = ST_SEND_LO;
         ST_SEND_LO:   if (tx_ready) w_next = w_rest;
         default:      w_next = ST_IDLE;
      endcase
   end

   // Accumulation, sample index, conversion timeout and the latched average.
   always_ff @(posedge clk_adc or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_idx   <= '0;
         r_tmo   <= '0;
         r_frame <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_acc <= '0;
               r_idx <= '0;
            end
            ST_START: r_tmo <= '0;
            ST_CONVERT: begin
               if (adc_done) begin
                  if (w_last) begin
                     r_frame <= w_avg;
                     r_acc   <= '0;
                     r_idx   <= '0;
                  end else begin
                     r_acc <= w_sum;
                     r_idx <= w_idx_inc;
                  end
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs, decoded from the next state so they align with the state they belong to.
   always_ff @(posedge clk_adc or negedge rst_n) begin
      if (!rst_n) begin
         r_adc_start   <= 1'b0;
         r_tx_valid    <= 1'b0;
         r_tx_data     <= '0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_adc_start <= (w_next == ST_START);
         r_tx_valid  <= (w_next == ST_SEND_HI) || (w_next == ST_SEND_LO);
         if (r_state == ST_CONVERT && w_next == ST_SEND_HI)
            r_tx_data <= frame_hi_byte(w_hi_nib);
         else if (r_state == ST_SEND_HI && w_next == ST_SEND_LO)
            r_tx_data <= FRAME_LO_BITS'(r_frame);
         else if (w_next != ST_SEND_HI && w_next != ST_SEND_LO)
            r_tx_data <= '0;
         if (r_state == ST_SEND_LO && tx_ready)
            r_frame_count <= r_frame_count + 16'd1;
         // A new error event wins over a simultaneous clear.
         r_overrun     <= w_tick_drop | (r_overrun & ~clr_err);
         r_timeout_err <= w_tmo_hit | (r_timeout_err & ~clr_err);
      end
   end

   assign adc_start   = r_adc_start;
   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_tx_data;
   assign overrun     = r_overrun;
   assign timeout_err = r_timeout_err;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - directed and randomized checks of adc_sample_scheduler
module tb_adc_sample_scheduler;

   localparam int PERIOD = 20;
   localparam int NS     = 4;

   logic        clk_adc  = 1'b0;
   logic        rst_n    = 1'b0;
   logic        enable   = 1'b0;
   logic        adc_done = 1'b0;
   logic [11:0] adc_data = '0;
   logic        tx_ready = 1'b0;
   logic        clr_err  = 1'b0;
   logic        adc_start;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        overrun;
   logic        timeout_err;
   logic [15:0] frame_count;

   int total      = 0;
   int bad        = 0;
   int cyc_n      = 0;
   int prev_start = -1;
   int exp_count  = 0;
   int samples[$];

   always #5 clk_adc = ~clk_adc;

   adc_sample_scheduler #(
      .DATA_BITS      (12),
      .PERIOD_CYCLES  (PERIOD),
      .AVG_LOG2       (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_adc     (clk_adc),
      .rst_n       (rst_n),
      .enable      (enable),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_data    (adc_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .clr_err     (clr_err),
      .frame_count (frame_count)
   );

   task automatic cyc();
      @(posedge clk_adc);
      #1;
      cyc_n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for a conversion request, checks tick spacing and the one-cycle pulse.
   task automatic wait_start();
      int n = 0;
      while (adc_start !== 1'b1 && n < 200) begin
         cyc();
         n++;
      end
      chk("start_seen", adc_start, 1);
      if (prev_start >= 0) chk("start_spacing", cyc_n - prev_start, PERIOD);
      prev_start = cyc_n;
      cyc();
      chk("start_one_cycle", adc_start, 0);
   endtask

   // Answers one conversion lat cycles after the request; the model records the value.
   task automatic do_sample(input logic [11:0] d, input int lat);
      wait_start();
      repeat (lat - 1) cyc();
      adc_done = 1'b1;
      adc_data = d;
      cyc();
      adc_done = 1'b0;
      adc_data = '0;
      samples.push_back(int'(d));
   endtask

   task automatic group_avg(output logic [11:0] avg);
      int sum = 0;
      foreach (samples[i]) sum += samples[i];
      samples.delete();
      avg = 12'(sum / NS);
   endtask

   // Accepts one byte after holding tx_ready low for stall cycles.
   task automatic get_byte(input string tag, input logic [7:0] exp, input int stall);
      int n = 0;
      while (tx_valid !== 1'b1 && n < 200) begin
         cyc();
         n++;
      end
      chk({tag, "_valid"}, tx_valid, 1);
      for (int i = 0; i < stall; i++) begin
         chk({tag, "_hold"}, {tx_valid, adc_start, tx_data}, {1'b1, 1'b0, exp});
         cyc();
      end
      tx_ready = 1'b1;
      chk({tag, "_data"}, tx_data, exp);
      cyc();
      tx_ready = 1'b0;
   endtask

   task automatic expect_frame(input int st_hi, input int st_lo);
      logic [11:0] avg;
      chk("valid_after_last_done", tx_valid, 1);
      group_avg(avg);
      get_byte("hi", 8'h80 | {4'h0, avg[11:8]}, st_hi);
      chk("lo_follows", tx_valid, 1);
      get_byte("lo", avg[7:0], st_lo);
      exp_count++;
      chk("frame_count", frame_count, exp_count);
      chk("valid_drop", tx_valid, 0);
   endtask

   initial begin
      logic [11:0] avg;
      logic        seen;
      int          k;

      repeat (3) cyc();
      chk("rst_flags", {adc_start, tx_valid, overrun, timeout_err}, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_frame_count", frame_count, 0);
      rst_n  = 1'b1;
      enable = 1'b1;

      do_sample(12'h100, 2);
      do_sample(12'h104, 1);
      do_sample(12'h108, 3);
      do_sample(12'h10C, 1);
      expect_frame(0, 0);

      for (int f = 0; f < 6; f++) begin
         for (int s = 0; s < NS; s++) do_sample(12'($urandom), $urandom_range(1, 6));
         expect_frame($urandom_range(0, 3), $urandom_range(0, 3));
      end
      chk("no_errors", {overrun, timeout_err}, 0);

      for (int s = 0; s < NS; s++) do_sample(12'($urandom), $urandom_range(1, 4));
      expect_frame(50, 0);
      chk("stall_overrun", overrun, 1);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("overrun_cleared", overrun, 0);
      prev_start = -1;

      do_sample(12'($urandom), 2);
      do_sample(12'($urandom), 3);
      wait_start();
      k = 1;
      while (timeout_err !== 1'b1 && k < 100) begin
         cyc();
         k++;
      end
      chk("timeout_latency", (k >= 64 && k <= 66), 1);
      chk("timeout_overrun", overrun, 1);
      prev_start = -1;
      do_sample(12'($urandom), 1);
      do_sample(12'($urandom), 2);
      expect_frame(0, 1);
      chk("timeout_sticky", timeout_err, 1);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("errors_cleared", {overrun, timeout_err}, 0);
      prev_start = -1;

      do_sample(12'($urandom), 1);
      do_sample(12'($urandom), 2);
      wait_start();
      enable = 1'b0;
      cyc();
      adc_done = 1'b1;
      adc_data = 12'hABC;
      cyc();
      adc_done = 1'b0;
      samples.delete();
      seen = 1'b0;
      repeat (40) begin
         seen = seen | adc_start | tx_valid;
         cyc();
      end
      chk("idle_quiet", seen, 0);
      chk("drop_frame_count", frame_count, exp_count);
      enable     = 1'b1;
      prev_start = -1;
      for (int s = 0; s < NS; s++) do_sample(12'($urandom), $urandom_range(1, 4));
      expect_frame(1, 1);

      for (int s = 0; s < NS; s++) do_sample(12'($urandom), 1);
      group_avg(avg);
      get_byte("rst_hi", 8'h80 | {4'h0, avg[11:8]}, 0);
      chk("in_send_lo", tx_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_flags", {adc_start, tx_valid, overrun, timeout_err}, 0);
      chk("async_rst_data", tx_data, 0);
      chk("async_rst_count", frame_count, 0);
      exp_count = 0;
      cyc();
      cyc();
      rst_n      = 1'b1;
      prev_start = -1;
      for (int s = 0; s < NS - 1; s++) begin
         do_sample(12'($urandom), $urandom_range(1, 4));
         chk("no_early_valid", tx_valid, 0);
      end
      do_sample(12'($urandom), 2);
      expect_frame(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
